// File: rtl/serial_pattern_tx_if.sv
// Load port and serial output bundle of serial_pattern_tx.
// The slave modport is the transmitter side; the master modport is the loader/consumer side.
interface serial_pattern_tx_if #(
  parameter int MAX_LEN = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic [7:0]         rep;
  logic               abort;
  logic               x;
  logic               x_valid;
  logic               frame_start;
  logic               done;
  logic               err;
  logic               busy;

  // A load is taken on a rising edge where load_valid && load_ready; load_ready is high only in IDLE,
  // and fields need only be stable at that edge.
  modport slave (
    input  load_valid, pattern, length, rep, abort,
    output load_ready, x, x_valid, frame_start, done, err, busy
  );

  modport master (
    output load_valid, pattern, length, rep, abort,
    input  load_ready, x, x_valid, frame_start, done, err, busy
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial stimulus transmitter: shifts a loaded pattern out LSB-first with repetitions,
// optional inter-frame gaps and frame markers. All outputs are registered.
module serial_pattern_tx #(
  parameter int MAX_LEN    = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  serial_pattern_tx_if.slave bus,
  output logic [1:0]    state_dbg
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [7:0] GAP_M1 = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat_q, pat_n, pat_shifted;
  logic [LEN_W-1:0]   len_q, len_n, idx_q, idx_n;
  logic [7:0]         rep_q, rep_n, gap_q, gap_n;
  logic               reject;
  logic               legal_len;
  logic               x_n, x_valid_n, frame_start_n, done_n, err_n, busy_n, load_ready_n;

  assign state_dbg = state;
  assign legal_len = (bus.length >= LEN_W'(2)) && (bus.length <= LEN_W'(MAX_LEN));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      pat_q           <= '0;
      len_q           <= '0;
      idx_q           <= '0;
      rep_q           <= '0;
      gap_q           <= '0;
      bus.x           <= 1'b0;
      bus.x_valid     <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.load_ready  <= 1'b1;
    end else begin
      state           <= state_n;
      pat_q           <= pat_n;
      len_q           <= len_n;
      idx_q           <= idx_n;
      rep_q           <= rep_n;
      gap_q           <= gap_n;
      bus.x           <= x_n;
      bus.x_valid     <= x_valid_n;
      bus.frame_start <= frame_start_n;
      bus.done        <= done_n;
      bus.err         <= err_n;
      bus.busy        <= busy_n;
      bus.load_ready  <= load_ready_n;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    len_n   = len_q;
    idx_n   = idx_q;
    rep_n   = rep_q;
    gap_n   = gap_q;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        // abort wins over a simultaneous load, so an aborting master never starts a new frame
        if (bus.load_valid && !bus.abort) begin
          if (legal_len) begin
            state_n = SHIFT;
            pat_n   = bus.pattern;
            len_n   = bus.length;
            rep_n   = bus.rep;
            idx_n   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (idx_q == len_q - LEN_W'(1)) begin
          if (rep_q == 8'd0) begin
            state_n = DONE;
          end else begin
            rep_n = rep_q - 8'd1;
            idx_n = '0;
            if (GAP_CYCLES == 0) begin
              state_n = SHIFT;
            end else begin
              state_n = GAP;
              gap_n   = GAP_M1;
            end
          end
        end else begin
          idx_n = idx_q + LEN_W'(1);
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (gap_q == 8'd0) begin
          state_n = SHIFT;
        end else begin
          gap_n = gap_q - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are the registered image of the state being entered; a frame begins whenever SHIFT is entered at bit 0.
  always_comb begin
    pat_shifted   = pat_n >> idx_n;
    x_valid_n     = (state_n == SHIFT);
    x_n           = x_valid_n & pat_shifted[0];
    frame_start_n = x_valid_n && (idx_n == '0);
    done_n        = (state_n == DONE);
    err_n         = reject;
    busy_n        = (state_n != IDLE);
    load_ready_n  = (state_n == IDLE);
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (no gap, two-cycle gap) share stimulus and are each
// compared every cycle against a timeline model of the expected serial stream.
module tb_serial_pattern_tx;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  serial_pattern_tx_if #(.MAX_LEN(MAX_LEN)) b0 ();
  serial_pattern_tx_if #(.MAX_LEN(MAX_LEN)) b2 ();
  logic [1:0] dbg0, dbg2;

  serial_pattern_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .bus(b0), .state_dbg(dbg0));
  serial_pattern_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .bus(b2), .state_dbg(dbg2));

  int errs   = 0;
  int checks = 0;

  // Model: per instance, whether a load is in flight and how many cycles since its accept edge.
  int          gaps [2] = '{0, 2};
  logic        m_act[2];
  logic        m_err[2];
  int          m_t  [2];
  int          m_len[2];
  int          m_rep[2];
  logic [15:0] m_pat[2];

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          rep;
    logic        exp_err;
    int          lat0;
    int          lat2;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {load_ready, busy, err, done, frame_start, x_valid, x}
  function automatic logic [6:0] model_out(input int d);
    int total, period, o;
    if (!m_act[d]) return {1'b1, 1'b0, m_err[d], 4'b0000};
    total  = m_len[d] * (m_rep[d] + 1) + gaps[d] * m_rep[d];
    if (m_t[d] == total + 1) return 7'b0101000;
    period = m_len[d] + gaps[d];
    o      = (m_t[d] - 1) % period;
    if (o < m_len[d]) return {4'b0100, (o == 0), 1'b1, m_pat[d][o]};
    return 7'b0100000;
  endfunction

  function automatic logic [6:0] dut_out(input int d);
    if (d == 0) return {b0.load_ready, b0.busy, b0.err, b0.done, b0.frame_start, b0.x_valid, b0.x};
    return {b2.load_ready, b2.busy, b2.err, b2.done, b2.frame_start, b2.x_valid, b2.x};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_err[d] = 1'b0; m_t[d] = 0;
      m_len[d] = 0; m_rep[d] = 0; m_pat[d] = '0;
    end
  endtask

  task automatic model_edge(input logic lv, input logic [15:0] pat, input int len,
                            input int rp, input logic ab);
    int total;
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      if (m_act[d]) begin
        total = m_len[d] * (m_rep[d] + 1) + gaps[d] * m_rep[d];
        if (ab) m_act[d] = 1'b0;
        else begin
          m_t[d]++;
          if (m_t[d] > total + 1) m_act[d] = 1'b0;
        end
      end else if (lv && !ab) begin
        if (len >= 2 && len <= MAX_LEN) begin
          m_act[d] = 1'b1; m_t[d] = 1;
          m_pat[d] = pat; m_len[d] = len; m_rep[d] = rp;
        end else begin
          m_err[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out_gap0", 64'(dut_out(0)), 64'(model_out(0)));
    check("out_gap2", 64'(dut_out(1)), 64'(model_out(1)));
  endtask

  task automatic cycle(input logic lv, input logic [15:0] pat, input logic [LEN_W-1:0] len,
                       input logic [7:0] rp, input logic ab);
    b0.load_valid = lv; b0.pattern = pat; b0.length = len; b0.rep = rp; b0.abort = ab;
    b2.load_valid = lv; b2.pattern = pat; b2.length = len; b2.rep = rp; b2.abort = ab;
    model_edge(lv, pat, int'(len), int'(rp), ab);
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 5'd0, 8'd0, 1'b0);
  endtask

  initial begin
    int n, lat0, lat2, fs0, fs2;
    logic [15:0] xs;

    tbl[0] = '{16'h0118, 10, 0, 1'b0, 11, 11};
    tbl[1] = '{16'h0005,  3, 2, 1'b0, 10, 14};
    tbl[2] = '{16'h0001,  2, 3, 1'b0,  9, 15};
    tbl[3] = '{16'hA5C3, 16, 1, 1'b0, 33, 35};
    tbl[4] = '{16'h0002,  2, 0, 1'b0,  3,  3};
    tbl[5] = '{16'h00FF,  0, 0, 1'b1,  0,  0};
    tbl[6] = '{16'h00FF, 17, 0, 1'b1,  0,  0};

    model_reset();
    RESET = 1'b1;
    b0.load_valid = 1'b0; b0.pattern = '0; b0.length = '0; b0.rep = '0; b0.abort = 1'b0;
    b2.load_valid = 1'b0; b2.pattern = '0; b2.length = '0; b2.rep = '0; b2.abort = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    compare_all();
    RESET = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, tbl[i].pat, 5'(tbl[i].len), 8'(tbl[i].rep), 1'b0);
      if (tbl[i].exp_err) begin
        check("err_pulse", 64'({b0.err, b2.err}), 64'(2'b11));
        check("err_no_valid", 64'({b0.x_valid, b2.x_valid, b0.busy, b2.busy}), 64'(0));
        idle_cycles(2);
      end else begin
        n = 1; lat0 = 0; lat2 = 0; fs0 = 0; fs2 = 0; xs = '0;
        while (n < 200) begin
          if (n <= 16) xs[n-1] = b0.x;
          if (b0.frame_start) fs0++;
          if (b2.frame_start) fs2++;
          if (b0.done && lat0 == 0) lat0 = n;
          if (b2.done && lat2 == 0) lat2 = n;
          if (lat0 != 0 && lat2 != 0) break;
          idle_cycles(1);
          n++;
        end
        check("done_latency_gap0", 64'(lat0), 64'(tbl[i].lat0));
        check("done_latency_gap2", 64'(lat2), 64'(tbl[i].lat2));
        check("frames_gap0", 64'(fs0), 64'(tbl[i].rep + 1));
        check("frames_gap2", 64'(fs2), 64'(tbl[i].rep + 1));
        if (i == 0) check("x_seq_0x118", 64'(xs[9:0]), 64'(10'b01_0001_1000));
        idle_cycles(1);
        check("ready_after_done", 64'({b0.load_ready, b2.load_ready}), 64'(2'b11));
      end
    end

    // Abort while bit 4 of a 10-bit frame is on the line, then reload at once.
    cycle(1'b1, 16'h03FF, 5'd10, 8'd0, 1'b0);
    idle_cycles(4);
    cycle(1'b0, 16'h0, 5'd0, 8'd0, 1'b1);
    check("abort_idle", 64'({b0.x_valid, b0.done, b0.load_ready, b2.x_valid, b2.done, b2.load_ready}),
          64'(6'b001001));
    cycle(1'b1, 16'h0001, 5'd2, 8'd0, 1'b0);
    check("reload_bit0", 64'({b0.x, b0.frame_start, b2.x, b2.frame_start}), 64'(4'b1111));
    idle_cycles(4);

    // Asynchronous reset between edges in the middle of a frame.
    cycle(1'b1, 16'h1234, 5'd8, 8'd1, 1'b0);
    idle_cycles(2);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check("async_reset_gap0", 64'(dut_out(0)), 64'(7'b1000000));
    check("async_reset_gap2", 64'(dut_out(1)), 64'(7'b1000000));
    @(negedge CLK);
    compare_all();
    RESET = 1'b0;
    cycle(1'b1, 16'h0005, 5'd3, 8'd0, 1'b0);
    idle_cycles(6);

    for (int i = 0; i < 1500; i++) begin
      logic lv, ab;
      ab = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 3) == 0) && !ab;
      cycle(lv, 16'($urandom), 5'($urandom_range(0, 17)), 8'($urandom_range(0, 3)), ab);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
